// File: rtl/uart_pkg.sv
// Shared serial-link definitions used by both the frame transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input; both stages reset to 1
// so an idle-high line looks idle straight out of reset.
module bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Metastability filter chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Oversampling serial receiver: finds the start bit, samples each bit at its
// midpoint and delivers the byte in parallel with a one-cycle valid strobe.
module sipo_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic                 sr_clk,
  input  logic                 reset,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  logic                 line_s;
  logic                 line_q;
  rx_state_t            state_r;
  logic [TW-1:0]        tick_r;
  logic [2:0]           bitn_r;
  logic [DATA_BITS-1:0] shreg_r;

  bit_sync u_sync (
    .clk   (sr_clk),
    .reset (reset),
    .d     (data_in),
    .q     (line_s)
  );

  // Previous synchronized sample for falling-edge detection.
  always_ff @(posedge sr_clk or posedge reset) begin
    if (reset) begin
      line_q <= 1'b1;
    end else begin
      line_q <= line_s;
    end
  end

  // Frame FSM; START counts only to the start-bit midpoint, so every later
  // full-bit count lands on a bit centre, and STOP ends at the stop midpoint.
  always_ff @(posedge sr_clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      tick_r    <= '0;
      bitn_r    <= 3'd0;
      shreg_r   <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        IDLE: begin
          tick_r <= '0;
          if (line_q && !line_s) begin
            state_r <= START;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        START: begin
          if (tick_r == TICK_MID) begin
            tick_r <= '0;
            bitn_r <= 3'd0;
            if (!line_s) begin
              state_r <= DATA;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            tick_r <= tick_r + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_r == TICK_LAST) begin
            tick_r  <= '0;
            shreg_r <= {line_s, shreg_r[DATA_BITS-1:1]};
            if (bitn_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bitn_r <= bitn_r + 3'd1;
            end
          end else begin
            tick_r <= tick_r + TICK_ONE;
          end
        end
        STOP: begin
          if (tick_r == TICK_LAST) begin
            tick_r  <= '0;
            state_r <= IDLE;
            busy    <= 1'b0;
            if (line_s) begin
              data_out <= shreg_r;
              valid    <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            tick_r <= tick_r + TICK_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          tick_r  <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: the driver queues the expected outcome of each
// frame it sends, and a monitor checks every valid/frame_err pulse against it.
module tb_sipo_rx;

  localparam int OS      = 16;
  localparam int LATENCY = 2 + OS / 2 + 9 * OS + 1;

  logic       sr_clk;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  sipo_rx #(.OVERSAMPLE(OS)) dut (
    .sr_clk    (sr_clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  typedef struct {
    logic        err;
    logic [7:0]  data;
    int unsigned exp_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc;
  int          n_cmp;
  int          n_bad;
  logic [7:0]  last_good;

  initial sr_clk = 1'b0;
  always #5 sr_clk = ~sr_clk;

  always @(posedge sr_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Sends start bit, 8 data bits LSB first, then the given stop bit; must be
  // called right after a falling clock edge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0]  bits;
    int unsigned start;
    exp_t        e;
    bits  = {stop, b, 1'b0};
    start = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        e.err     = ~stop;
        e.data    = b;
        e.exp_cyc = start + LATENCY;
        exp_q.push_back(e);
      end
      data_in = bits[i];
      repeat (OS) @(negedge sr_clk);
    end
  endtask

  // Monitor: pops one expectation per output pulse, and tracks the held byte.
  always @(negedge sr_clk) begin
    exp_t e;
    if (reset) begin
      last_good = 8'h00;
    end else begin
      if (valid && frame_err) chk("valid_and_err_together", 32'd1, 32'd0);
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, valid, frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.err});
          chk("pulse_latency", cyc, e.exp_cyc);
          chk("busy_at_pulse", {31'd0, busy}, 32'd0);
          if (!e.err) begin
            chk("rx_byte", {24'd0, data_out}, {24'd0, e.data});
            last_good = e.data;
          end
        end
      end
      chk("data_out_held", {24'd0, data_out}, {24'd0, last_good});
    end
  end

  initial begin
    int busy_cnt;
    logic [7:0] b;
    logic stop;
    int gap;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    last_good = 8'h00;
    data_in = 1'b1;
    reset = 1'b1;

    // Reset with line idle.
    repeat (3) begin
      @(negedge sr_clk);
      chk("rst_data_out", {24'd0, data_out}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    #2 reset = 1'b0;
    repeat (20) @(negedge sr_clk);

    // Single frame, then back-to-back frames with no idle bits.
    send_frame(8'h43, 1'b1);
    data_in = 1'b1;
    repeat (2 * OS) @(negedge sr_clk);
    send_frame(8'h99, 1'b1);
    send_frame(8'h43, 1'b1);
    data_in = 1'b1;
    repeat (2 * OS) @(negedge sr_clk);

    // Short low glitch: busy only through the start-midpoint check.
    busy_cnt = 0;
    data_in = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge sr_clk);
      if (busy) busy_cnt++;
      if (k == 6) data_in = 1'b1;
    end
    chk("glitch_busy_cycles", busy_cnt, 32'd8);
    send_frame(8'hA5, 1'b1);
    data_in = 1'b1;
    repeat (2 * OS) @(negedge sr_clk);

    // Good frame, then a framing error followed by a break.
    send_frame(8'h43, 1'b1);
    send_frame(8'h99, 1'b0);
    data_in = 1'b0;
    busy_cnt = 0;
    repeat (100) begin
      @(negedge sr_clk);
      if (busy) busy_cnt++;
    end
    chk("break_busy_cycles", busy_cnt, 32'd0);
    data_in = 1'b1;
    repeat (3 * OS) @(negedge sr_clk);

    // Reset in the middle of data bit 4.
    data_in = 1'b0;
    repeat (OS) @(negedge sr_clk);
    b = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      data_in = b[i];
      repeat (OS) @(negedge sr_clk);
    end
    data_in = b[4];
    repeat (OS / 2) @(negedge sr_clk);
    #2 reset = 1'b1;
    data_in = 1'b1;
    #1;
    chk("midrst_data_out", {24'd0, data_out}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge sr_clk);
    #2 reset = 1'b0;
    repeat (10 * OS) @(negedge sr_clk);
    send_frame(8'h5A, 1'b1);
    data_in = 1'b1;
    repeat (2 * OS) @(negedge sr_clk);

    // Random frames, stop bits, idle gaps and sub-half-bit glitches.
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      data_in = 1'b1;
      gap = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      repeat (gap * OS) @(negedge sr_clk);
      if ($urandom_range(0, 2) == 0) begin
        data_in = 1'b0;
        repeat ($urandom_range(1, OS / 2 - 1)) @(negedge sr_clk);
        data_in = 1'b1;
        repeat (24) @(negedge sr_clk);
      end
    end

    // Drain with a bounded wait.
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge sr_clk);
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("missing_pulse", {23'd0, e.err, e.data}, 32'hFFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
